// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle fetch/decode/execute/mem/writeback sequencer with retire counter
// Optional handshake timeout guarded by WAIT_TIMEOUT_EN.
module core_sequencer #(
    parameter int unsigned     PC_W     = 10,
    parameter int unsigned     PC_STEP  = 1,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     TIMEOUT  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            im_ready,
    output logic            im_enable,
    output logic            im_read,
    output logic [PC_W-1:0] pc,
    input  logic            is_load,
    input  logic            is_store,
    input  logic            is_branch,
    input  logic            branch_taken,
    input  logic            writes_reg,
    input  logic [PC_W-1:0] branch_target,
    output logic            enable_fetch,
    output logic            enable_execute,
    output logic            enable_writeback,
    output logic            reg_write,
    input  logic            dm_ready,
    output logic            dm_enable,
    output logic            dm_read,
    output logic            dm_write,
    input  logic            halt_req,
    output logic            halted,
    output logic            bus_error,
    output logic [2:0]      state,
    output logic [31:0]     retired
);
    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] target_q, target_d;
    logic [31:0]     retired_q, retired_d;
    logic            load_q, load_d;
    logic            store_q, store_d;
    logic            redirect_q, redirect_d;
    logic            wr_q, wr_d;
    logic            retire;

`ifdef WAIT_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              bus_error_q, bus_error_d;
    logic              waiting;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        target_d   = target_q;
        retired_d  = retired_q;
        load_d     = load_q;
        store_d    = store_q;
        redirect_d = redirect_q;
        wr_d       = wr_q;
        retire     = 1'b0;

        case (state_q)
            S_FETCH: if (im_ready) state_d = S_DECODE;
            S_DECODE: begin
                // Load wins when the decoder flags both load and store.
                load_d     = is_load;
                store_d    = is_store & ~is_load;
                redirect_d = is_branch & branch_taken;
                wr_d       = writes_reg;
                target_d   = branch_target;
                state_d    = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (load_q || store_q) state_d = S_MEM;
                else if (wr_q)         state_d = S_WB;
                else                   retire  = 1'b1;
            end
            S_MEM: begin
                if (dm_ready) begin
                    if (load_q) state_d = S_WB;
                    else        retire  = 1'b1;
                end
            end
            S_WB:    retire = 1'b1;
            default: state_d = state_q;
        endcase

        if (retire) begin
            pc_d      = redirect_q ? target_q : pc_q + PC_W'(PC_STEP);
            retired_d = retired_q + 32'd1;
            state_d   = halt_req ? S_HALT : S_FETCH;
        end

`ifdef WAIT_TIMEOUT_EN
        // Counter only advances while stalled; any exit clears it, so entry always starts at zero.
        waiting     = (state_q == S_FETCH && !im_ready) || (state_q == S_MEM && !dm_ready);
        bus_error_d = bus_error_q;
        wait_d      = '0;
        if (waiting) begin
            if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                bus_error_d = 1'b1;
                state_d     = S_HALT;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            target_q   <= '0;
            retired_q  <= '0;
            load_q     <= 1'b0;
            store_q    <= 1'b0;
            redirect_q <= 1'b0;
            wr_q       <= 1'b0;
`ifdef WAIT_TIMEOUT_EN
            wait_q      <= '0;
            bus_error_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            target_q   <= target_d;
            retired_q  <= retired_d;
            load_q     <= load_d;
            store_q    <= store_d;
            redirect_q <= redirect_d;
            wr_q       <= wr_d;
`ifdef WAIT_TIMEOUT_EN
            wait_q      <= wait_d;
            bus_error_q <= bus_error_d;
`endif
        end
    end

    assign im_enable        = ~rst & (state_q == S_FETCH);
    assign im_read          = ~rst & (state_q == S_FETCH);
    assign enable_fetch     = ~rst & (state_q == S_DECODE);
    assign enable_execute   = ~rst & (state_q == S_EXECUTE);
    assign enable_writeback = ~rst & (state_q == S_WB);
    assign reg_write        = ~rst & (state_q == S_WB) & (wr_q | load_q);
    assign dm_enable        = ~rst & (state_q == S_MEM);
    assign dm_read          = ~rst & (state_q == S_MEM) & load_q;
    assign dm_write         = ~rst & (state_q == S_MEM) & store_q;
    assign halted           = ~rst & (state_q == S_HALT);
    assign pc               = pc_q;
    assign retired          = retired_q;
    assign state            = state_q;

`ifdef WAIT_TIMEOUT_EN
    assign bus_error = bus_error_q;
`else
    assign bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - scoreboard bench for core_sequencer with randomized instruction stream
`timescale 1ns/1ps
module tb_core_sequencer;
    localparam int unsigned PC_W   = 10;
    localparam logic [9:0]  RST_PC = 10'h3F0;

    logic        clk = 1'b0;
    logic        rst;
    logic        im_ready, im_enable, im_read;
    logic [9:0]  pc;
    logic        is_load, is_store, is_branch, branch_taken, writes_reg;
    logic [9:0]  branch_target;
    logic        enable_fetch, enable_execute, enable_writeback, reg_write;
    logic        dm_ready, dm_enable, dm_read, dm_write;
    logic        halt_req, halted, bus_error;
    logic [2:0]  state;
    logic [31:0] retired;

    core_sequencer #(.PC_W(PC_W), .PC_STEP(1), .RESET_PC(RST_PC), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .im_ready(im_ready), .im_enable(im_enable), .im_read(im_read),
        .pc(pc), .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
        .branch_taken(branch_taken), .writes_reg(writes_reg), .branch_target(branch_target),
        .enable_fetch(enable_fetch), .enable_execute(enable_execute),
        .enable_writeback(enable_writeback), .reg_write(reg_write), .dm_ready(dm_ready),
        .dm_enable(dm_enable), .dm_read(dm_read), .dm_write(dm_write), .halt_req(halt_req),
        .halted(halted), .bus_error(bus_error), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    wire [8:0] strobes = {im_enable, im_read, enable_fetch, enable_execute, enable_writeback,
                          reg_write, dm_enable, dm_read, dm_write};

    typedef struct {
        logic [9:0]  pc;
        logic [31:0] ret;
        int          len;
        int          wb;
        int          rd;
        int          wr;
    } exp_t;

    exp_t        exp_q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [9:0]  m_pc;
    logic [31:0] m_ret;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [31:0] prev_ret;
        int          c_len, c_wb, c_rw, c_rd, c_wr;
        prev_ret = '0;
        c_len = 0; c_wb = 0; c_rw = 0; c_rd = 0; c_wr = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ret = retired;
                c_len = 0; c_wb = 0; c_rw = 0; c_rd = 0; c_wr = 0;
            end else begin
                if (retired !== prev_ret) begin
                    check("sb_has_expectation", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("sb_pc", pc, e.pc);
                        check("sb_retired", retired, e.ret);
                        check("sb_cycles", c_len, e.len);
                        check("sb_writeback_cycles", c_wb, e.wb);
                        check("sb_reg_write_pulses", c_rw, e.wb);
                        check("sb_dm_read_cycles", c_rd, e.rd);
                        check("sb_dm_write_cycles", c_wr, e.wr);
                    end
                    prev_ret = retired;
                    c_len = 0; c_wb = 0; c_rw = 0; c_rd = 0; c_wr = 0;
                end
                if (|strobes)         c_len++;
                if (enable_writeback) c_wb++;
                if (reg_write)        c_rw++;
                if (dm_read)          c_rd++;
                if (dm_write)         c_wr++;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic imr, input logic dmr, input logic hr);
        im_ready = imr;
        dm_ready = dmr;
        halt_req = hr;
        @(posedge clk);
        #1;
    endtask

    task automatic garbage();
        {is_load, is_store, is_branch, branch_taken, writes_reg} = 5'($urandom);
        branch_target = 10'($urandom);
    endtask

    function automatic logic hsel(input bit last, input bit hlt);
        return last ? hlt : ($urandom % 4 == 0);
    endfunction

    task automatic run_instr(input bit ld, input bit st, input bit br, input bit tk, input bit wr,
                             input logic [9:0] tgt, input int wi, input int wd, input bit hlt);
        exp_t e;
        bit   load, store, mem, wb;
        int   len, c;
        load  = ld;
        store = st && !ld;
        mem   = load || store;
        wb    = load || (!mem && wr);
        len   = (wi + 1) + 2 + (mem ? wd + 1 : 0) + (wb ? 1 : 0);
        m_pc  = (br && tk) ? tgt : 10'(m_pc + 10'd1);
        m_ret = m_ret + 32'd1;
        e.pc = m_pc; e.ret = m_ret; e.len = len;
        e.wb = wb ? 1 : 0; e.rd = load ? wd + 1 : 0; e.wr = store ? wd + 1 : 0;
        exp_q.push_back(e);
        c = 0;
        for (int i = 0; i <= wi; i++) begin
            garbage();
            drive(i == wi, 1'($urandom), hsel(c == len - 1, hlt)); c++;
        end
        {is_load, is_store, is_branch, branch_taken, writes_reg} = {ld, st, br, tk, wr};
        branch_target = tgt;
        drive(1'($urandom), 1'($urandom), hsel(c == len - 1, hlt)); c++;
        garbage();
        drive(1'($urandom), 1'($urandom), hsel(c == len - 1, hlt)); c++;
        if (mem) begin
            for (int i = 0; i <= wd; i++) begin
                garbage();
                drive(1'($urandom), i == wd, hsel(c == len - 1, hlt)); c++;
            end
        end
        if (wb) begin
            garbage();
            drive(1'($urandom), 1'($urandom), hsel(c == len - 1, hlt)); c++;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            garbage();
            drive(1'($urandom), 1'($urandom), 1'($urandom));
        end
        check("rst_strobes", strobes, 9'd0);
        check("rst_halted", halted, 1'b0);
        check("rst_state", state, 3'd0);
        check("rst_pc", pc, RST_PC);
        check("rst_retired", retired, 32'd0);
        check("rst_bus_error", bus_error, 1'b0);
        m_pc  = RST_PC;
        m_ret = '0;
        rst   = 1'b0;
    endtask

    task automatic rand_instr(input bit hlt);
        run_instr($urandom % 4 == 0, $urandom % 4 == 0, $urandom % 3 == 0, 1'($urandom),
                  1'($urandom), 10'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), hlt);
    endtask

    initial begin : stimulus
        rst = 1'b1;
        garbage();
        im_ready = 1'b0; dm_ready = 1'b0; halt_req = 1'b0;
        do_reset(3);

        for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 0, 1, 10'h0, 0, 0, 0);
        check("alu_retired_after_12", retired, 32'd3);
        check("alu_pc_after_12", pc, 10'h3F3);

        run_instr(0, 0, 1, 1, 0, 10'h010, 0, 0, 0);
        run_instr(0, 0, 1, 1, 0, 10'h005, 0, 0, 0);
        run_instr(0, 0, 1, 1, 0, 10'h010, 0, 0, 0);
        run_instr(0, 0, 1, 0, 0, 10'h2AA, 0, 0, 0);
        run_instr(1, 0, 0, 0, 0, 10'h0, 0, 2, 0);
        run_instr(1, 1, 0, 0, 0, 10'h0, 1, 1, 0);
        run_instr(0, 0, 1, 1, 0, 10'h3FF, 0, 0, 0);
        run_instr(0, 1, 0, 0, 1, 10'h0, 0, 0, 0);
        check("store_wrap_pc", pc, 10'h000);

        for (int i = 0; i < 150; i++) rand_instr(0);

        garbage(); drive(1, 0, 0);
        is_load = 1; is_store = 0; is_branch = 0; writes_reg = 0; drive(0, 0, 0);
        garbage(); drive(0, 0, 0);
        for (int i = 0; i < 3; i++) begin garbage(); drive(1'($urandom), 0, 0); end
        check("abort_mem_state", state, 3'd3);
        do_reset(2);
        check("abort_queue_empty", exp_q.size(), 0);

        for (int i = 0; i < 10; i++) rand_instr(0);
        rand_instr(1);
        check("halt_halted", halted, 1'b1);
        check("halt_state", state, 3'd5);
        for (int i = 0; i < 8; i++) begin
            garbage();
            drive(1, 1, 1'($urandom));
        end
        check("halt_pc_frozen", pc, m_pc);
        check("halt_retired_frozen", retired, m_ret);
        check("halt_still_halted", state, 3'd5);
        check("halt_no_strobes", strobes, 9'd0);
        check("halt_queue_empty", exp_q.size(), 0);
        do_reset(2);

        garbage();
`ifdef WAIT_TIMEOUT_EN
        for (int i = 0; i < 15; i++) drive(0, 1'($urandom), 0);
        check("to_fetch_before_limit", state, 3'd0);
        check("to_no_error_before_limit", bus_error, 1'b0);
        drive(0, 0, 0);
        check("to_state_halt", state, 3'd5);
        check("to_bus_error", bus_error, 1'b1);
        check("to_retired_unchanged", retired, m_ret);
        check("to_pc_unchanged", pc, m_pc);
`else
        for (int i = 0; i < 100; i++) drive(0, 1'($urandom), 0);
        check("nowait_state_fetch", state, 3'd0);
        check("nowait_bus_error", bus_error, 1'b0);
        check("nowait_im_enable", im_enable, 1'b1);
        check("nowait_retired", retired, m_ret);
`endif
        do_reset(2);
        drive(0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
